// File: rtl/ttl_down_counter_reload.sv
// WIDTH-bit synchronous down counter with parallel load, ENT/ENP enables,
// ripple-borrow output for cascading and optional auto-reload from the last
// loaded value on underflow (divide-by-(N+1) source).
module ttl_down_counter_reload #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Load_bar,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             Reload_en,
    input  logic [WIDTH-1:0] D,
    output logic             RBO,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // DELAY_RISE/DELAY_FALL describe board-level propagation for behavioural
    // library models; this synthesizable view adds no delay, so only their
    // sanity is checked here.
    generate
        if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
            $error("ttl_down_counter_reload: output delays must be non-negative");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_preset;
    logic             w_zero;
    logic             w_count;

    assign w_zero  = (r_q == '0);
    assign w_count = Load_bar && ENT && ENP;

    // Counter state: Clear beats Load, Load beats count, otherwise hold.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_q <= '0;
        end else if (!Load_bar) begin
            r_q <= D;
        end else if (w_count) begin
            if (!w_zero) begin
                r_q <= r_q - ONE;
            end else if (Reload_en) begin
                r_q <= r_preset;
            end else begin
                r_q <= '1;
            end
        end
    end

    // Reload target: only Clear and Load ever change it.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_preset <= '0;
        end else if (!Load_bar) begin
            r_preset <= D;
        end
    end

    // Borrow is gated by ENT only, so a cascade's upper stage steps exactly
    // when the lower stage underflows.
    assign RBO = ENT && w_zero;
    assign Q   = r_q;

endmodule

// File: tb/tb_ttl_down_counter_reload.sv
module tb_ttl_down_counter_reload;

    logic       Clk = 1'b0;
    logic       Clear, Load_bar, ENT, ENP, Reload_en;
    logic [3:0] D;
    logic       RBO;
    logic [3:0] Q;

    logic       c_clear, c_load_bar, c_ent, c_enp, c_reload;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_rbo, hi_rbo;

    int n_tests = 0;
    int n_fail  = 0;
    int m_q      = 0;
    int m_preset = 0;

    always #5 Clk = ~Clk;

    ttl_down_counter_reload #(.WIDTH(4), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk(Clk), .Clear(Clear), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
        .Reload_en(Reload_en), .D(D), .RBO(RBO), .Q(Q)
    );

    ttl_down_counter_reload #(.WIDTH(4), .DELAY_RISE(0), .DELAY_FALL(0)) u_lo (
        .Clk(Clk), .Clear(c_clear), .Load_bar(c_load_bar), .ENT(c_ent), .ENP(c_enp),
        .Reload_en(c_reload), .D(c_d[3:0]), .RBO(lo_rbo), .Q(lo_q)
    );

    ttl_down_counter_reload #(.WIDTH(4), .DELAY_RISE(0), .DELAY_FALL(0)) u_hi (
        .Clk(Clk), .Clear(c_clear), .Load_bar(c_load_bar), .ENT(lo_rbo), .ENP(c_enp),
        .Reload_en(c_reload), .D(c_d[7:4]), .RBO(hi_rbo), .Q(hi_q)
    );

    // Reference: one rising edge of a modulo-16 down counter with a preset.
    task automatic model_edge();
        if (Clear) begin
            m_q = 0;
            m_preset = 0;
        end else if (!Load_bar) begin
            m_q = int'(D);
            m_preset = int'(D);
        end else if (ENT && ENP) begin
            if (m_q != 0)       m_q = (m_q + 16 - 1) % 16;
            else if (Reload_en) m_q = m_preset;
            else                m_q = 15;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic clr, input logic lb, input logic t,
                          input logic p, input logic rl, input logic [3:0] d);
        Clear = clr; Load_bar = lb; ENT = t; ENP = p; Reload_en = rl; D = d;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1, 1, 1, 4'hA);
        tick();
        n_tests++;
        if (Q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", Q); end
        ENT = 1; #1;
        n_tests++;
        if (RBO !== 1'b1) begin n_fail++; $display("FAIL reset_rbo_ent1: got %b want 1", RBO); end
        ENT = 0; #1;
        n_tests++;
        if (RBO !== 1'b0) begin n_fail++; $display("FAIL reset_rbo_ent0: got %b want 0", RBO); end
        // cleared preset: reload from 0 keeps Q at 0 with RBO high
        set_in(0, 1, 1, 1, 1, 4'h7);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (Q !== 4'h0 || RBO !== 1'b1) begin
                n_fail++; $display("FAIL reset_preset_zero: got Q=%h RBO=%b want Q=0 RBO=1", Q, RBO);
            end
        end
    endtask

    task automatic test_free_count();
        int exp_q[5] = '{2, 1, 0, 15, 14};
        set_in(0, 0, 1, 1, 0, 4'h3);
        tick();
        n_tests++;
        if (Q !== 4'h3) begin n_fail++; $display("FAIL free_load: got %h want 3", Q); end
        Load_bar = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (Q !== 4'(exp_q[i]) || RBO !== (exp_q[i] == 0)) begin
                n_fail++;
                $display("FAIL free_count[%0d]: got Q=%h RBO=%b want Q=%h RBO=%b",
                         i, Q, RBO, exp_q[i], exp_q[i] == 0);
            end
        end
    endtask

    task automatic test_reload();
        int exp_q[7] = '{1, 0, 2, 1, 0, 2, 1};
        int pulses = 0;
        set_in(0, 0, 1, 1, 1, 4'h2);
        tick();
        Load_bar = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (RBO === 1'b1) pulses++;
            n_tests++;
            if (Q !== 4'(exp_q[i]) || RBO !== (exp_q[i] == 0)) begin
                n_fail++;
                $display("FAIL reload_seq[%0d]: got Q=%h RBO=%b want Q=%h RBO=%b",
                         i, Q, RBO, exp_q[i], exp_q[i] == 0);
            end
        end
        n_tests++;
        if (pulses != 2) begin n_fail++; $display("FAIL reload_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_gating();
        set_in(0, 0, 1, 1, 0, 4'h5);
        tick();
        set_in(0, 1, 1, 0, 0, 4'h5);
        tick(); tick();
        n_tests++;
        if (Q !== 4'h5) begin n_fail++; $display("FAIL gate_enp: got %h want 5", Q); end
        set_in(0, 1, 0, 1, 0, 4'h5);
        tick();
        n_tests++;
        if (Q !== 4'h5 || RBO !== 1'b0) begin
            n_fail++; $display("FAIL gate_ent: got Q=%h RBO=%b want Q=5 RBO=0", Q, RBO);
        end
        set_in(0, 0, 0, 1, 0, 4'h0);
        tick();
        n_tests++;
        if (Q !== 4'h0 || RBO !== 1'b0) begin
            n_fail++; $display("FAIL gate_ent_zero: got Q=%h RBO=%b want Q=0 RBO=0", Q, RBO);
        end
        set_in(0, 0, 1, 1, 0, 4'h9);
        tick();
        n_tests++;
        if (Q !== 4'h9) begin n_fail++; $display("FAIL gate_load_priority: got %h want 9", Q); end
        set_in(0, 0, 1, 1, 1, 4'h0);
        tick();
        n_tests++;
        if (Q !== 4'h0 || RBO !== 1'b1) begin
            n_fail++; $display("FAIL load_zero: got Q=%h RBO=%b want Q=0 RBO=1", Q, RBO);
        end
    endtask

    task automatic test_mid_clear();
        set_in(0, 0, 1, 1, 1, 4'h6);
        tick();
        Load_bar = 1;
        tick(); tick(); tick();
        n_tests++;
        if (Q !== 4'h3) begin n_fail++; $display("FAIL clear_precount: got %h want 3", Q); end
        Clear = 1;
        tick();
        Clear = 0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (Q !== 4'h0) begin n_fail++; $display("FAIL clear_mid[%0d]: got %h want 0", i, Q); end
            tick();
        end
    endtask

    task automatic test_reload_change();
        set_in(0, 0, 1, 1, 0, 4'h1);
        tick();
        Load_bar = 1;
        tick();
        ENP = 0; Reload_en = 1;
        tick(); tick();
        n_tests++;
        if (Q !== 4'h0) begin n_fail++; $display("FAIL reload_no_immediate: got %h want 0", Q); end
        ENP = 1;
        tick();
        n_tests++;
        if (Q !== 4'h1) begin n_fail++; $display("FAIL reload_at_underflow: got %h want 1", Q); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Clear     = ($urandom_range(0, 31) == 0);
            Load_bar  = ($urandom_range(0, 7) != 0);
            ENT       = ($urandom_range(0, 5) != 0);
            ENP       = ($urandom_range(0, 5) != 0);
            Reload_en = 1'($urandom_range(0, 1));
            D         = 4'($urandom_range(0, 15));
            tick();
            n_tests++;
            if (Q !== 4'(m_q) || RBO !== (ENT && m_q == 0)) begin
                n_fail++;
                $display("FAIL random[%0d]: got Q=%h RBO=%b want Q=%h RBO=%b",
                         i, Q, RBO, m_q, ENT && m_q == 0);
            end
        end
    endtask

    task automatic c_tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_cascade();
        int v;
        c_clear = 0; c_reload = 0; c_ent = 1; c_enp = 1;
        c_load_bar = 0; c_d = 8'h10;
        c_tick();
        c_load_bar = 1;
        c_tick();
        n_tests++;
        if ({hi_q, lo_q} !== 8'h0F || hi_rbo !== 1'b0) begin
            n_fail++; $display("FAIL cascade_10: got %h rbo=%b want 0f rbo=0", {hi_q, lo_q}, hi_rbo);
        end
        c_load_bar = 0; c_d = 8'h00;
        c_tick();
        n_tests++;
        if ({hi_q, lo_q} !== 8'h00 || hi_rbo !== 1'b1) begin
            n_fail++; $display("FAIL cascade_00: got %h rbo=%b want 00 rbo=1", {hi_q, lo_q}, hi_rbo);
        end
        c_load_bar = 1;
        c_tick();
        n_tests++;
        if ({hi_q, lo_q} !== 8'hFF || hi_rbo !== 1'b0) begin
            n_fail++; $display("FAIL cascade_ff: got %h rbo=%b want ff rbo=0", {hi_q, lo_q}, hi_rbo);
        end
        for (int k = 0; k < 4; k++) begin
            v = $urandom_range(0, 255);
            c_load_bar = 0; c_d = 8'(v);
            c_tick();
            c_load_bar = 1;
            for (int j = 0; j < 40; j++) begin
                c_enp = ($urandom_range(0, 3) != 0);
                if (c_enp) v = (v + 255) % 256;
                c_tick();
                n_tests++;
                if ({hi_q, lo_q} !== 8'(v) || hi_rbo !== (v == 0)) begin
                    n_fail++;
                    $display("FAIL cascade_rand[%0d.%0d]: got %h rbo=%b want %h rbo=%b",
                             k, j, {hi_q, lo_q}, hi_rbo, v, v == 0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_in(1, 1, 0, 0, 0, 4'h0);
        c_clear = 1; c_load_bar = 1; c_ent = 1; c_enp = 0; c_reload = 0; c_d = 8'h00;
        #1;
        test_reset();
        test_free_count();
        test_reload();
        test_gating();
        test_mid_clear();
        test_reload_change();
        test_random();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
